// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency inst ROM and hands
// {pc, inst} downstream with a valid/stall handshake. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] rom_addr_out,
   input  logic [31:0] rom_data_in,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        valid_out,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic        fetch_fault_out
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_RUN   = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [XLEN-1:0] pend_pc;
   logic [XLEN-1:0] pend_pc_next;
   logic [XLEN-1:0] skid_inst;
   logic [XLEN-1:0] skid_inst_next;
   logic [XLEN-1:0] inst_next;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] pc_plus4_next;
   logic            valid_next;
   logic            fault_next;
   logic            slot_free;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic            misalign;
   assign misalign = redirect_in && (redirect_pc_in[1:0] != 2'b00);
`endif

   assign rom_addr_out = fetch_pc;
   assign slot_free    = !valid_out || !stall_in;

   // State register and all datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_EMPTY;
         fetch_pc        <= RESET_PC;
         pend_pc         <= '0;
         skid_inst       <= '0;
         valid_out       <= 1'b0;
         inst_out        <= '0;
         pc_out          <= '0;
         pc_plus4_out    <= '0;
         fetch_fault_out <= 1'b0;
      end else begin
         state           <= state_next;
         fetch_pc        <= fetch_pc_next;
         pend_pc         <= pend_pc_next;
         skid_inst       <= skid_inst_next;
         valid_out       <= valid_next;
         inst_out        <= inst_next;
         pc_out          <= pc_next;
         pc_plus4_out    <= pc_plus4_next;
         fetch_fault_out <= fault_next;
      end
   end

   // Next-state and next-output logic; redirect outranks stall.
   always_comb begin
      state_next     = state;
      fetch_pc_next  = fetch_pc;
      pend_pc_next   = pend_pc;
      skid_inst_next = skid_inst;
      valid_next     = valid_out;
      inst_next      = inst_out;
      pc_next        = pc_out;
      pc_plus4_next  = pc_plus4_out;
      fault_next     = fetch_fault_out;

      if (fetch_fault_out) begin
         // A trapped fetch stays frozen until reset.
         state_next = ST_EMPTY;
         valid_next = 1'b0;
      end else if (redirect_in) begin
         valid_next = 1'b0;
         state_next = ST_EMPTY;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misalign) begin
            fault_next = 1'b1;
         end else begin
            fetch_pc_next = redirect_pc_in & ALIGN_MASK;
         end
`else
         fetch_pc_next = redirect_pc_in & ALIGN_MASK;
`endif
      end else begin
         case (state)
            ST_EMPTY: begin
               pend_pc_next  = fetch_pc;
               fetch_pc_next = fetch_pc + PC_STEP;
               state_next    = ST_RUN;
               if (slot_free) begin
                  valid_next = 1'b0;
               end
            end
            ST_RUN: begin
               if (slot_free) begin
                  inst_next     = rom_data_in;
                  pc_next       = pend_pc;
                  pc_plus4_next = pend_pc + PC_STEP;
                  valid_next    = 1'b1;
                  pend_pc_next  = fetch_pc;
                  fetch_pc_next = fetch_pc + PC_STEP;
               end else begin
                  // Park the in-flight word; the read issued this cycle is re-issued later.
                  skid_inst_next = rom_data_in;
                  state_next     = ST_SKID;
               end
            end
            ST_SKID: begin
               if (!stall_in) begin
                  inst_next     = skid_inst;
                  pc_next       = pend_pc;
                  pc_plus4_next = pend_pc + PC_STEP;
                  valid_next    = 1'b1;
                  pend_pc_next  = fetch_pc;
                  fetch_pc_next = fetch_pc + PC_STEP;
                  state_next    = ST_RUN;
               end
            end
            default: begin
               state_next = ST_EMPTY;
               valid_next = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: ROM word at address a is ~a; a negedge monitor
// pops expected PCs for every accepted instruction.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] rom_addr_out;
   logic [31:0] rom_data;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        valid_out;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic        fetch_fault_out;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   bit          model_mode = 1'b0;
   logic [31:0] model_pc = 32'h0;
   int          emitted = 0;

   always #5 clock = ~clock;

   always @(posedge clock) rom_data <= ~rom_addr_out;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clock          (clock),
      .reset          (reset),
      .rom_addr_out   (rom_addr_out),
      .rom_data_in    (rom_data),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .valid_out      (valid_out),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .pc_plus4_out   (pc_plus4_out),
      .fetch_fault_out(fetch_fault_out)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   // Monitor: an instruction counts as delivered when presented, not stalled and not flushed.
   always @(negedge clock) begin
      logic [31:0] e;
      if (!reset && valid_out && !stall_in && !redirect_in) begin
         emitted++;
         e = 32'h0;
         if (model_mode) begin
            e = model_pc;
            model_pc = model_pc + 32'd4;
            check32("rand_pc", pc_out, e);
         end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_emit actual=%h required=none", pc_out);
            e = pc_out;
         end else begin
            e = exp_q.pop_front();
            check32("seq_pc", pc_out, e);
         end
         check32("inst", inst_out, ~e);
         check32("pc_plus4", pc_plus4_out, e + 32'd4);
      end
   end

   task automatic push_run(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         step();
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_seg(input string name, input logic [31:0] target, input logic [31:0] first, input int n);
      redirect_in    = 1'b1;
      redirect_pc_in = target;
      push_run(first, n);
      step();
      redirect_in = 1'b0;
      check32({name, "_bubble"}, {31'b0, valid_out}, 32'd0);
      drain(name);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int rand_start;
      reset          = 1'b1;
      stall_in       = 1'b0;
      redirect_in    = 1'b0;
      redirect_pc_in = 32'h0;
      repeat (3) step();

      check32("rst_valid", {31'b0, valid_out}, 32'd0);
      check32("rst_inst", inst_out, 32'h0);
      check32("rst_pc", pc_out, 32'h0);
      check32("rst_pc4", pc_plus4_out, 32'h0);
      check32("rst_fault", {31'b0, fetch_fault_out}, 32'd0);
      check32("rst_rom_addr", rom_addr_out, 32'h0);

      // Startup latency, then a 3-cycle stall while pc_out=8.
      push_run(32'h0, 6);
      reset = 1'b0;
      step();
      check32("lat_edge1_valid", {31'b0, valid_out}, 32'd0);
      step();
      check32("lat_edge2_valid", {31'b0, valid_out}, 32'd1);
      check32("lat_edge2_pc", pc_out, 32'h0);
      step();
      check32("run_pc4", pc_out, 32'h4);
      step();
      check32("run_pc8", pc_out, 32'h8);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check32("stall_hold_pc", pc_out, 32'h8);
         check32("stall_hold_valid", {31'b0, valid_out}, 32'd1);
      end
      stall_in = 1'b0;
      step();
      check32("release_pc12", pc_out, 32'hC);
      step();
      check32("release_pc16", pc_out, 32'h10);
      drain("stall_seq");

      // Redirect to 0x40 while stalled at pc_out=8: 8 and 12 never delivered.
      do_reset();
      push_run(32'h0, 2);
      push_run(32'h40, 4);
      repeat (4) step();
      check32("pre_redir_pc8", pc_out, 32'h8);
      stall_in = 1'b1;
      step();
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h40;
      step();
      redirect_in = 1'b0;
      stall_in    = 1'b0;
      check32("redir_bubble1", {31'b0, valid_out}, 32'd0);
      step();
      check32("redir_bubble2", {31'b0, valid_out}, 32'd0);
      step();
      check32("redir_valid", {31'b0, valid_out}, 32'd1);
      check32("redir_pc40", pc_out, 32'h40);
      step();
      check32("redir_pc44", pc_out, 32'h44);
      drain("redir_seq");

      // PC wraps modulo 2^32.
      run_seg("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 4);

      // Random stall/redirect against an in-order PC model.
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h100;
      model_pc       = 32'h100;
      model_mode     = 1'b1;
      step();
      redirect_in = 1'b0;
      rand_start  = emitted;
      for (int c = 0; c < 3000; c++) begin
         stall_in = ($urandom_range(0, 99) < 40);
         if ($urandom_range(0, 99) < 3) begin
            redirect_in    = 1'b1;
            redirect_pc_in = 32'($urandom_range(0, 1023)) << 2;
            model_pc       = redirect_pc_in;
         end else begin
            redirect_in = 1'b0;
         end
         step();
      end
      stall_in       = 1'b0;
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h200;
      step();
      model_mode  = 1'b0;
      redirect_in = 1'b0;
      checks++;
      if (emitted - rand_start < 800) begin
         failures++;
         $display("FAIL rand_throughput actual=%0d required>=800", emitted - rand_start);
      end
      do_reset();
      step();
      step();

      // Misaligned redirect to 0x42.
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h42;
      step();
      redirect_in = 1'b0;
      check32("trap_fault", {31'b0, fetch_fault_out}, 32'd1);
      check32("trap_valid", {31'b0, valid_out}, 32'd0);
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h80;
      step();
      redirect_in = 1'b0;
      repeat (4) step();
      check32("trap_hold_fault", {31'b0, fetch_fault_out}, 32'd1);
      check32("trap_hold_valid", {31'b0, valid_out}, 32'd0);
      do_reset();
      check32("trap_clear_fault", {31'b0, fetch_fault_out}, 32'd0);
      exp_q.delete();
      push_run(32'h0, 3);
      drain("trap_restart");
`else
      run_seg("misalign", 32'h42, 32'h40, 3);
      check32("no_fault", {31'b0, fetch_fault_out}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
